mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
// Handshake: the master holds dmem_req and all request fields stable until the cycle
// where dmem_ack is high; an ack while dmem_req is low carries no meaning and is dropped.
interface mem_access_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores on the data bus, stalls until ack or timeout.
// Optional macro MISALIGN_CHECK_EN rejects misaligned half/word accesses with a misalign pulse.
module mem_access_unit #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] alu_result,
   input  logic [4:0]  rd_in,
   mem_access_unit_if.master dmem,
   output logic        stall,
   output logic [31:0] wb_mem_data,
   output logic [31:0] wb_alu_data,
   output logic [4:0]  wb_rd,
   output logic        wb_valid,
   output logic        bus_err,
   output logic        misalign,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      r_state, w_next_state, w_eff_state;
   logic [7:0]  r_wait_cnt;
   logic        r_req, r_we, r_bus_err, r_is_load, r_sext;
   logic [31:0] r_addr, r_wdata, r_cap, r_hold_alu;
   logic [3:0]  r_be;
   logic [4:0]  r_hold_rd;
   logic [1:0]  r_lane, r_size;

   logic        w_mem_op, w_misalign, w_accept, w_ack_hit, w_timeout;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata, w_load_fmt;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;

   assign w_mem_op = valid_in & (mem_read | mem_write);

`ifdef MISALIGN_CHECK_EN
   assign w_misalign = w_mem_op & (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_accept  = (r_state == S_IDLE) & w_mem_op & ~w_misalign;
   assign w_ack_hit = (r_state == S_WAIT) & dmem.dmem_ack;
   assign w_timeout = (r_state == S_WAIT) & ~dmem.dmem_ack & (r_wait_cnt == WAIT_LAST);

   // Store lane steering; a load always requests the full word.
   always_comb begin
      w_st_be    = 4'hF;
      w_st_wdata = wdata;
      if (mem_write) begin
         case (size)
            2'b00: begin
               w_st_be    = 4'b0001 << addr[1:0];
               w_st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
               w_st_be    = addr[1] ? 4'b1100 : 4'b0011;
               w_st_wdata = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   assign w_ld_byte = dmem.dmem_rdata[{r_lane, 3'b000} +: 8];
   assign w_ld_half = dmem.dmem_rdata[{r_lane[1], 4'b0000} +: 16];

   always_comb begin
      case (r_size)
         2'b00:   w_load_fmt = r_sext ? {{24{w_ld_byte[7]}}, w_ld_byte} : {24'd0, w_ld_byte};
         2'b01:   w_load_fmt = r_sext ? {{16{w_ld_half[15]}}, w_ld_half} : {16'd0, w_ld_half};
         default: w_load_fmt = dmem.dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_WAIT;
         S_WAIT:  if (w_ack_hit || w_timeout) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= 8'd0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_be       <= 4'd0;
         r_cap      <= 32'd0;
         r_hold_alu <= 32'd0;
         r_hold_rd  <= 5'd0;
         r_lane     <= 2'd0;
         r_size     <= 2'd0;
         r_sext     <= 1'b0;
         r_is_load  <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
         if (w_accept) begin
            r_req      <= 1'b1;
            r_we       <= mem_write;
            r_addr     <= {addr[31:2], 2'b00};
            r_wdata    <= w_st_wdata;
            r_be       <= w_st_be;
            r_hold_alu <= alu_result;
            r_hold_rd  <= rd_in;
            r_lane     <= addr[1:0];
            r_size     <= size;
            r_sext     <= sign_ext;
            r_is_load  <= ~mem_write;
            r_wait_cnt <= 8'd0;
         end else if (w_ack_hit) begin
            r_req <= 1'b0;
            r_cap <= r_is_load ? w_load_fmt : 32'd0;
         end else if (w_timeout) begin
            r_req <= 1'b0;
            r_cap <= 32'd0;
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
      end
   end

   // While rst is high the handshake outputs behave as if the FSM were already idle.
   assign w_eff_state = rst ? S_IDLE : r_state;

   always_comb begin
      stall       = 1'b0;
      wb_valid    = 1'b0;
      wb_mem_data = 32'd0;
      wb_alu_data = alu_result;
      wb_rd       = rd_in;
      case (w_eff_state)
         S_IDLE: begin
            stall    = w_mem_op & ~w_misalign;
            wb_valid = valid_in & ~(mem_read | mem_write);
         end
         S_WAIT: begin
            stall       = 1'b1;
            wb_alu_data = r_hold_alu;
            wb_rd       = r_hold_rd;
         end
         S_DONE: begin
            wb_valid    = 1'b1;
            wb_mem_data = r_cap;
            wb_alu_data = r_hold_alu;
            wb_rd       = r_hold_rd;
         end
         default: ;
      endcase
   end

   assign misalign        = w_misalign & ~rst & (r_state == S_IDLE);
   assign bus_err         = r_bus_err;
   assign o_dbg_state     = r_state;
   assign dmem.dmem_req   = r_req;
   assign dmem.dmem_we    = r_we;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_wdata = r_wdata;
   assign dmem.dmem_be    = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with MAX_WAIT=4; inputs change on the falling edge
// and outputs are sampled 1 time unit later.
module tb_mem_access_unit;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, mem_read, mem_write, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, alu_result;
   logic [4:0]  rd_in;
   logic        stall, wb_valid, bus_err, misalign;
   logic [31:0] wb_mem_data, wb_alu_data;
   logic [4:0]  wb_rd;
   logic [1:0]  dbg_state;

   int n_assert = 0;
   int n_fail   = 0;

   mem_access_unit_if bus ();

   mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .mem_read(mem_read), .mem_write(mem_write),
      .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .alu_result(alu_result), .rd_in(rd_in),
      .dmem(bus),
      .stall(stall), .wb_mem_data(wb_mem_data), .wb_alu_data(wb_alu_data),
      .wb_rd(wb_rd), .wb_valid(wb_valid), .bus_err(bus_err), .misalign(misalign),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; afterwards the bench is on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] alu, input logic [4:0] rdi);
      valid_in = v; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
      addr = a; wdata = wd; alu_result = alu; rd_in = rdi;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
   endtask

   // Load accepted now, acked in the first WAIT cycle; checks the formatted DONE data.
   task automatic run_load(input string tag, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] rdata, input logic [31:0] exp);
      drive(1'b1, 1'b1, 1'b0, sz, sx, a, 32'd0, 32'h0000_0BAD, 5'd11);
      #1 chk({tag, "_accept_stall"}, 32'(stall), 32'd1);
      cyc(); idle_in();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
      #1 chk({tag, "_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
      cyc();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      #1 chk({tag, "_data"}, wb_mem_data, exp);
      chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
      cyc();
   endtask

   // Store accepted now; checks lane steering in WAIT then acks.
   task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      drive(1'b1, 1'b0, 1'b1, sz, 1'b0, a, wd, 32'd0, 5'd1);
      cyc(); idle_in();
      bus.dmem_ack = 1'b1;
      #1 chk({tag, "_be"}, 32'(bus.dmem_be), 32'(exp_be));
      chk({tag, "_wdata"}, bus.dmem_wdata, exp_wd);
      cyc();
      bus.dmem_ack = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      cyc(); cyc();
      #1 chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_req", 32'(bus.dmem_req), 32'd0);
      chk("rst_we", 32'(bus.dmem_we), 32'd0);
      chk("rst_addr", bus.dmem_addr, 32'd0);
      chk("rst_be", 32'(bus.dmem_be), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      cyc(); rst = 1'b0;

      // Non-memory op passes through in the same cycle.
      drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'h1234, 5'd7);
      #1 chk("alu_wb_alu", wb_alu_data, 32'h1234);
      chk("alu_wb_rd", 32'(wb_rd), 32'd7);
      chk("alu_wb_valid", 32'(wb_valid), 32'd1);
      chk("alu_stall", 32'(stall), 32'd0);
      chk("alu_wb_mem", wb_mem_data, 32'd0);

      // Signed byte load from lane 3, ack on the first WAIT cycle.
      cyc();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'hAAAA, 5'd3);
      #1 chk("lb_stall_c1", 32'(stall), 32'd1);
      chk("lb_wb_valid_c1", 32'(wb_valid), 32'd0);
      cyc(); idle_in();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80FF_FF00;
      #1 chk("lb_state_wait", 32'(dbg_state), 32'd1);
      chk("lb_req", 32'(bus.dmem_req), 32'd1);
      chk("lb_stall_c2", 32'(stall), 32'd1);
      chk("lb_addr", bus.dmem_addr, 32'h100);
      chk("lb_be", 32'(bus.dmem_be), 32'hF);
      chk("lb_we", 32'(bus.dmem_we), 32'd0);
      cyc();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      #1 chk("lb_done_stall", 32'(stall), 32'd0);
      chk("lb_done_valid", 32'(wb_valid), 32'd1);
      chk("lb_done_data", wb_mem_data, 32'hFFFF_FF80);
      chk("lb_done_alu", wb_alu_data, 32'hAAAA);
      chk("lb_done_rd", 32'(wb_rd), 32'd3);
      chk("lb_done_req", 32'(bus.dmem_req), 32'd0);
      chk("lb_done_bus_err", 32'(bus_err), 32'd0);
      cyc();
      #1 chk("lb_back_idle", 32'(dbg_state), 32'd0);
      chk("lb_idle_valid", 32'(wb_valid), 32'd0);

      // Half store with read and write both high: behaves as a store, acked on WAIT cycle 3.
      cyc();
      drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 32'h55, 5'd9);
      #1 chk("sh_stall_c1", 32'(stall), 32'd1);
      cyc(); idle_in();
      #1 chk("sh_be", 32'(bus.dmem_be), 32'hC);
      chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
      chk("sh_we", 32'(bus.dmem_we), 32'd1);
      chk("sh_addr", bus.dmem_addr, 32'h20);
      cyc();
      #1 chk("sh_wait2_req", 32'(bus.dmem_req), 32'd1);
      cyc();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
      #1 chk("sh_wait3_stall", 32'(stall), 32'd1);
      cyc();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      #1 chk("sh_done_valid", 32'(wb_valid), 32'd1);
      chk("sh_done_data", wb_mem_data, 32'd0);
      chk("sh_done_rd", 32'(wb_rd), 32'd9);
      chk("sh_done_alu", wb_alu_data, 32'h55);
      chk("sh_done_bus_err", 32'(bus_err), 32'd0);
      cyc();

      // Load that is never acked: four WAIT cycles then DONE with bus_err.
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h77, 5'd4);
      cyc(); idle_in();
      for (int i = 0; i < MAX_WAIT; i++) begin
         #1 chk($sformatf("to_req_w%0d", i), 32'(bus.dmem_req), 32'd1);
         chk($sformatf("to_stall_w%0d", i), 32'(stall), 32'd1);
         cyc();
      end
      #1 chk("to_done_state", 32'(dbg_state), 32'd2);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_data", wb_mem_data, 32'd0);
      chk("to_valid", 32'(wb_valid), 32'd1);
      chk("to_req_low", 32'(bus.dmem_req), 32'd0);
      cyc();
      bus.dmem_ack = 1'b1;
      #1 chk("to_bus_err_clear", 32'(bus_err), 32'd0);
      cyc();
      bus.dmem_ack = 1'b0;
      #1 chk("idle_ack_ignored_state", 32'(dbg_state), 32'd0);
      chk("idle_ack_ignored_req", 32'(bus.dmem_req), 32'd0);

      // Reset on the second WAIT cycle, then a late ack.
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h99, 5'd5);
      cyc(); idle_in();
      cyc();
      rst = 1'b1;
      #1 chk("rstw_stall_idle_rule", 32'(stall), 32'd0);
      chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
      cyc();
      rst = 1'b0;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
      #1 chk("rstw_state", 32'(dbg_state), 32'd0);
      chk("rstw_req", 32'(bus.dmem_req), 32'd0);
      chk("rstw_wb_valid2", 32'(wb_valid), 32'd0);
      cyc();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      #1 chk("rstw_still_idle", 32'(dbg_state), 32'd0);
      chk("rstw_no_capture", 32'(wb_valid), 32'd0);
      cyc();

      // Misaligned word load.
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 32'h42, 5'd6);
`ifdef MISALIGN_CHECK_EN
      #1 chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_wb_valid", 32'(wb_valid), 32'd0);
      cyc(); idle_in();
      #1 chk("mis_state", 32'(dbg_state), 32'd0);
      chk("mis_req", 32'(bus.dmem_req), 32'd0);
      chk("mis_pulse_end", 32'(misalign), 32'd0);
      cyc();
`else
      #1 chk("mis_off_pulse", 32'(misalign), 32'd0);
      chk("mis_off_stall", 32'(stall), 32'd1);
      cyc(); idle_in();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
      #1 chk("mis_off_addr", bus.dmem_addr, 32'h100);
      chk("mis_off_req", 32'(bus.dmem_req), 32'd1);
      cyc();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      #1 chk("mis_off_data", wb_mem_data, 32'hCAFE_F00D);
      chk("mis_off_valid", 32'(wb_valid), 32'd1);
      cyc();
`endif

      // Remaining load extract and store steering cases.
      run_load("lhu", 2'b01, 1'b0, 32'h202, 32'h8001_0000, 32'h0000_8001);
      run_load("lh",  2'b01, 1'b1, 32'h200, 32'h1234_9ABC, 32'hFFFF_9ABC);
      run_load("lbu", 2'b00, 1'b0, 32'h301, 32'h0000_F500, 32'h0000_00F5);
      run_load("lb0", 2'b00, 1'b1, 32'h300, 32'h0000_007F, 32'h0000_007F);
      run_load("lw",  2'b11, 1'b1, 32'h404, 32'h8765_4321, 32'h8765_4321);
      run_store("sb", 2'b00, 32'h501, 32'h1234_5677, 4'b0010, 32'h7777_7777);
      run_store("sh0", 2'b01, 32'h600, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF);
      run_store("sw", 2'b10, 32'h708, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
